// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, encoded length per icode, fetch FSM states.
package y86_pkg;

  localparam int unsigned INSN_BYTES = 10;
  localparam int unsigned INSN_W     = 8 * INSN_BYTES;
  localparam int unsigned IDX_W      = 4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    HEAD,
    BODY,
    HOLD,
    HALT
  } fetch_state_e;

  // Encoded byte length of an instruction; undefined icodes fetch a single byte.
  function automatic logic [3:0] insn_len(input logic [3:0] icode);
    logic [3:0] len;
    case (icode)
      I_HALT, I_NOP, I_RET:               len = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:   len = 4'd2;
      I_JXX, I_CALL:                      len = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:       len = 4'd10;
      default:                            len = 4'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/y86_insn_buffer.sv
// 80-bit instruction assembly register, byte 0 in bits [0:7]; one byte lane written per cycle.
module y86_insn_buffer
  import y86_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [7:0]        wdata,
  output logic [0:INSN_W-1] data
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      data <= '0;
    end else if (we) begin
      for (int unsigned i = 0; i < INSN_BYTES; i++) begin
        if (idx == IDX_W'(i)) data[8*i +: 8] <= wdata;
      end
    end
  end

endmodule

// File: rtl/y86_fetch_unit.sv
// Y86-64 fetch stage: byte-serial instruction fetch, assembly into an 80-bit word,
// valid/ready handoff to decode, sequential PC update or redirect.
module y86_fetch_unit
  import y86_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 64,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter bit                STOP_ON_HALT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_rdata,
  input  logic              imem_err,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_new,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:INSN_W-1] instruction,
  output logic              imem_error,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] valP,
  output logic              halted
);

  fetch_state_e      state, state_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [3:0]        len, len_d;
  logic [ADDR_W-1:0] pc_d, addr_d, valp_d;
  logic              req_d, valid_d, err_d, halted_d;
  logic              buf_clr, buf_we;
  logic              ack_ok;
  logic              is_halt;
  logic [3:0]        byte_len;

  assign ack_ok = imem_req & imem_ack;

  y86_insn_buffer u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (buf_clr),
    .we    (buf_we),
    .idx   (idx),
    .wdata (imem_rdata),
    .data  (instruction)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= HEAD;
      pc_out     <= RESET_PC;
      idx        <= '0;
      len        <= '0;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      out_valid  <= 1'b0;
      imem_error <= 1'b0;
      valP       <= RESET_PC;
      halted     <= 1'b0;
    end else begin
      state      <= state_d;
      pc_out     <= pc_d;
      idx        <= idx_d;
      len        <= len_d;
      imem_req   <= req_d;
      imem_addr  <= addr_d;
      out_valid  <= valid_d;
      imem_error <= err_d;
      valP       <= valp_d;
      halted     <= halted_d;
    end
  end

  always_comb begin
    state_d  = state;
    pc_d     = pc_out;
    idx_d    = idx;
    len_d    = len;
    req_d    = imem_req;
    addr_d   = imem_addr;
    valid_d  = out_valid;
    err_d    = imem_error;
    valp_d   = valP;
    halted_d = halted;
    buf_clr  = 1'b0;
    buf_we   = 1'b0;
    byte_len = insn_len(imem_rdata[7:4]);
    is_halt  = (instruction[0:3] == I_HALT) && !imem_error;

    case (state)
      HEAD: begin
        req_d  = 1'b1;
        addr_d = pc_out;
        if (ack_ok && !imem_err) begin
          buf_we = 1'b1;
          len_d  = byte_len;
          if (byte_len == 4'd1) begin
            req_d   = 1'b0;
            valid_d = 1'b1;
            valp_d  = pc_out + ADDR_W'(1);
            state_d = HOLD;
          end else begin
            idx_d   = IDX_W'(1);
            addr_d  = pc_out + ADDR_W'(1);
            state_d = BODY;
          end
        end
      end
      BODY: begin
        if (ack_ok && !imem_err) begin
          buf_we = 1'b1;
          if (idx == len - 4'd1) begin
            req_d   = 1'b0;
            valid_d = 1'b1;
            valp_d  = pc_out + ADDR_W'(len);
            state_d = HOLD;
          end else begin
            idx_d  = idx + IDX_W'(1);
            addr_d = imem_addr + ADDR_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          err_d   = 1'b0;
          buf_clr = 1'b1;
          idx_d   = '0;
          pc_d    = valP;
          if (STOP_ON_HALT && is_halt) begin
            req_d    = 1'b0;
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            req_d   = 1'b1;
            addr_d  = valP;
            state_d = HEAD;
          end
        end
      end
      HALT: begin
        req_d = 1'b0;
      end
      default: begin
        state_d = HEAD;
      end
    endcase

    // A faulted byte ends the fetch; the unwritten lanes are already zero.
    if ((state == HEAD || state == BODY) && ack_ok && imem_err) begin
      buf_we  = 1'b0;
      req_d   = 1'b0;
      valid_d = 1'b1;
      err_d   = 1'b1;
      valp_d  = pc_out + ADDR_W'(1);
      state_d = HOLD;
    end

    // Redirect overrides everything, including an ack landing this cycle.
    if (pc_load) begin
      buf_we   = 1'b0;
      buf_clr  = 1'b1;
      idx_d    = '0;
      pc_d     = pc_new;
      req_d    = 1'b1;
      addr_d   = pc_new;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      halted_d = 1'b0;
      state_d  = HEAD;
    end
  end

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Bench for y86_fetch_unit: byte memory responder with random wait states and a
// reference model that assembles expected instructions directly from memory contents.
module tb_y86_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_rdata;
  logic        imem_err;
  logic        pc_load;
  logic [63:0] pc_new;
  logic        out_valid;
  logic        out_ready;
  logic [0:79] instruction;
  logic        imem_error;
  logic [63:0] pc_out;
  logic [63:0] valP;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem     [logic [63:0]];
  bit          err_map [logic [63:0]];
  logic [63:0] log_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] cur_pc;
  bit          zero_wait;
  int          len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};

  y86_fetch_unit #(
    .ADDR_W       (64),
    .RESET_PC     (64'h0),
    .STOP_ON_HALT (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .imem_err    (imem_err),
    .pc_load     (pc_load),
    .pc_new      (pc_new),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .instruction (instruction),
    .imem_error  (imem_error),
    .pc_out      (pc_out),
    .valP        (valP),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // Memory side: answers the held request, optionally after random waits; logs accepted reads.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 8'h00;
    imem_err   = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n === 1'b1 && imem_req === 1'b1 &&
          (zero_wait || $urandom_range(0, 2) == 0)) begin
        imem_ack   = 1'b1;
        imem_rdata = rd(imem_addr);
        imem_err   = err_map.exists(imem_addr);
        if (!pc_load) log_q.push_back(imem_addr);
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 8'($urandom);
        imem_err   = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic redirect(input logic [63:0] a);
    pc_load = 1'b1;
    pc_new  = a;
    @(negedge clk);
    pc_load = 1'b0;
    pc_new  = 64'($urandom);
    log_q.delete();
    checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== a) begin
      errors++;
      $display("FAIL redirect: valid=%b req=%b addr=%h required valid=0 req=1 addr=%h",
               out_valid, imem_req, imem_addr, a);
    end
  endtask

  // Waits for the instruction at pc, checks it against memory, holds `hold` cycles, accepts.
  task automatic expect_insn(input logic [63:0] pc, input int hold, input bit chk_lat);
    logic [0:79] ei;
    logic        ee;
    logic [63:0] ev;
    logic [63:0] a;
    logic [7:0]  b0;
    int          n;
    int          L;
    bit          bad;
    b0 = rd(pc);
    L  = len_tab[b0[7:4]];
    ei = '0;
    ee = 1'b0;
    exp_q.delete();
    for (int k = 0; k < L; k++) begin
      a = pc + 64'(k);
      exp_q.push_back(a);
      if (err_map.exists(a)) begin
        ee = 1'b1;
        break;
      end
      ei[8*k +: 8] = rd(a);
    end
    ev = ee ? pc + 64'd1 : pc + 64'(L);

    n = 0;
    while (out_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL valid_timeout pc=%h waited %0d cycles", pc, n);
    end
    if (chk_lat) begin
      checks++;
      if (n != exp_q.size()) begin
        errors++;
        $display("FAIL latency pc=%h got %0d required %0d", pc, n, exp_q.size());
      end
    end
    checks++;
    if (instruction !== ei) begin
      errors++;
      $display("FAIL instruction pc=%h got %h required %h", pc, instruction, ei);
    end
    checks++;
    if (imem_error !== ee) begin
      errors++;
      $display("FAIL imem_error pc=%h got %b required %b", pc, imem_error, ee);
    end
    checks++;
    if (pc_out !== pc) begin
      errors++;
      $display("FAIL pc_out got %h required %h", pc_out, pc);
    end
    checks++;
    if (valP !== ev) begin
      errors++;
      $display("FAIL valP pc=%h got %h required %h", pc, valP, ev);
    end
    bad = (log_q.size() != exp_q.size());
    if (!bad) foreach (exp_q[i]) if (log_q[i] !== exp_q[i]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL req_addrs pc=%h got %0d reads (first %h) required %0d reads from %h",
               pc, log_q.size(), (log_q.size() > 0) ? log_q[0] : 64'h0, exp_q.size(), pc);
    end
    if (hold > 0) begin
      bad = 1'b0;
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || instruction !== ei || valP !== ev ||
            pc_out !== pc || imem_req !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL frozen pc=%h valid=%b req=%b valP=%h required valid=1 req=0 valP=%h",
                 pc, out_valid, imem_req, valP, ev);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    log_q.delete();
    cur_pc = ev;
  endtask

  task automatic put_insn(input logic [63:0] pc, input bit with_err);
    logic [7:0] b;
    int         L;
    b = 8'($urandom);
    while (b[7:4] == 4'h0) b = 8'($urandom);
    mem[pc] = b;
    for (int k = 1; k < 10; k++) mem[pc + 64'(k)] = 8'($urandom);
    L = len_tab[b[7:4]];
    if (with_err && L > 1) err_map[pc + 64'($urandom_range(1, L - 1))] = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    pc_load   = 1'b0;
    pc_new    = '0;
    out_ready = 1'b0;
    zero_wait = 1'b1;
    mem[64'h0] = 8'h10;
    repeat (3) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0 || instruction !== 80'h0 ||
        imem_error !== 1'b0 || pc_out !== 64'h0 || valP !== 64'h0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_values req=%b valid=%b insn=%h err=%b pc=%h valP=%h halted=%b required all 0",
               imem_req, out_valid, instruction, imem_error, pc_out, valP, halted);
    end
    rst_n = 1'b1;
    log_q.delete();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      errors++;
      $display("FAIL first_req req=%b addr=%h required req=1 addr=0", imem_req, imem_addr);
    end
    expect_insn(64'h0, 0, 1'b0);
  endtask

  task automatic test_irmovq();
    logic [7:0] bytes [10] = '{8'h30, 8'hF3, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int k = 0; k < 10; k++) mem[64'h100 + 64'(k)] = bytes[k];
    zero_wait = 1'b1;
    redirect(64'h100);
    expect_insn(64'h100, 0, 1'b1);
  endtask

  task automatic test_jmp_stall();
    mem[64'h100] = 8'h70;
    for (int k = 1; k < 9; k++) mem[64'h100 + 64'(k)] = 8'($urandom);
    zero_wait = 1'b0;
    redirect(64'h100);
    expect_insn(64'h100, 5, 1'b0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h109) begin
      errors++;
      $display("FAIL next_req_after_jmp req=%b addr=%h required req=1 addr=109", imem_req, imem_addr);
    end
  endtask

  task automatic test_imem_err();
    mem[64'h20] = 8'h50;
    for (int k = 1; k < 10; k++) mem[64'h20 + 64'(k)] = 8'($urandom);
    err_map[64'h22] = 1'b1;
    zero_wait = 1'($urandom_range(0, 1));
    redirect(64'h20);
    expect_insn(64'h20, 1, 1'b0);
    err_map.delete();
  endtask

  task automatic test_redirect_mid();
    int n;
    bit saw;
    mem[64'h300] = 8'h80;
    for (int k = 1; k < 9; k++) mem[64'h300 + 64'(k)] = 8'($urandom);
    mem[64'h40] = 8'h20;
    mem[64'h41] = 8'h31;
    zero_wait = 1'b0;
    redirect(64'h300);
    n   = 0;
    saw = 1'b0;
    while (log_q.size() < 3 && n < 300) begin
      @(negedge clk);
      n++;
      if (out_valid === 1'b1) saw = 1'b1;
    end
    checks++;
    if (log_q.size() < 3 || saw) begin
      errors++;
      $display("FAIL mid_body reads=%0d early_valid=%b required reads>=3 early_valid=0", log_q.size(), saw);
    end
    redirect(64'h40);
    expect_insn(64'h40, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  prog [24] = '{8'h30, 8'hF3, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                               8'h10,
                               8'h20, 8'h12,
                               8'h70, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                               8'h60, 8'h01};
    int          lens [5] = '{10, 1, 2, 9, 2};
    logic [63:0] pc;
    int          n;
    int          off;
    for (int k = 0; k < 24; k++) mem[64'h500 + 64'(k)] = prog[k];
    zero_wait = 1'b1;
    redirect(64'h500);
    out_ready = 1'b1;
    pc  = 64'h500;
    off = 0;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (out_valid !== 1'b1 && n < 50);
      checks++;
      if (n != ((i == 0) ? lens[i] : lens[i] + 1) || instruction[0:7] !== prog[off] ||
          pc_out !== pc || valP !== pc + 64'(lens[i])) begin
        errors++;
        $display("FAIL b2b[%0d] cycles=%0d byte0=%h pc=%h valP=%h required cycles=%0d byte0=%h pc=%h valP=%h",
                 i, n, instruction[0:7], pc_out, valP, (i == 0) ? lens[i] : lens[i] + 1,
                 prog[off], pc, pc + 64'(lens[i]));
      end
      off += lens[i];
      pc  += 64'(lens[i]);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_halt();
    int bad;
    mem[64'h600] = 8'h00;
    mem[64'h0]   = 8'h10;
    zero_wait    = 1'b0;
    redirect(64'h600);
    expect_insn(64'h600, 0, 1'b0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (halted !== 1'b1 || imem_req !== 1'b0 || out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL halt_stop bad_cycles=%0d halted=%b req=%b required halted=1 req=0", bad, halted, imem_req);
    end
    redirect(64'h0);
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_resume halted=%b required 0", halted);
    end
    expect_insn(64'h0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int n;
    mem[64'h0] = 8'h10;
    zero_wait  = 1'b0;
    redirect(64'h100);
    n = 0;
    while (log_q.size() < 2 && n < 300) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0 || instruction !== 80'h0 ||
        pc_out !== 64'h0 || valP !== 64'h0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid req=%b valid=%b insn=%h pc=%h valP=%h required zeros",
               imem_req, out_valid, instruction, pc_out, valP);
    end
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      errors++;
      $display("FAIL reset_mid_req req=%b addr=%h required req=1 addr=0", imem_req, imem_addr);
    end
    expect_insn(64'h0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [63:0] pc;
    bit          zw;
    pc = 64'hFFFF_FFFF_FFFF_FFFA;
    put_insn(pc, 1'b0);
    zero_wait = 1'b1;
    redirect(pc);
    expect_insn(pc, 0, 1'b1);
    for (int it = 0; it < 40; it++) begin
      pc = cur_pc;
      put_insn(pc, $urandom_range(0, 4) == 0);
      zw        = 1'($urandom_range(0, 1));
      zero_wait = zw;
      expect_insn(pc, $urandom_range(0, 3), zw);
      err_map.delete();
    end
  endtask

  initial begin
    test_reset();
    test_irmovq();
    test_jmp_stall();
    test_imem_err();
    test_redirect_mid();
    test_back_to_back();
    test_halt();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
